// File: rtl/qpsk_pkg.sv
// Shared constants, tap table and output rounding for the QPSK pulse-shaping FIR.
// The tap set is symmetric, sums to 32768 (unity DC gain) and keeps every |tap| below 16384.
package qpsk_pkg;

  localparam int NTAPS     = 17;
  localparam int COEF_W    = 16;
  localparam int DATA_W    = 16;
  localparam int PROD_W    = 32;
  localparam int ACC_W     = PROD_W + $clog2(NTAPS);
  localparam int RND_SHIFT = 15;

  localparam logic signed [ACC_W-1:0] SAT_MAX = (1 <<< (DATA_W - 1)) - 1;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -(1 <<< (DATA_W - 1));

  localparam logic signed [COEF_W-1:0] COEF [NTAPS] = '{
    -16'sd200, -16'sd300, 16'sd0, 16'sd600, 16'sd1200, 16'sd2000, 16'sd2800, 16'sd3500,
    16'sd13568,
    16'sd3500, 16'sd2800, 16'sd2000, 16'sd1200, 16'sd600, 16'sd0, -16'sd300, -16'sd200
  };

  // Round half-up from Q1.15 scaling, then clip to the signed sample range.
  function automatic logic signed [DATA_W-1:0] round_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] rounded;
    rounded = (acc + ACC_W'(1 <<< (RND_SHIFT - 1))) >>> RND_SHIFT;
    if (rounded > SAT_MAX) begin
      return SAT_MAX[DATA_W-1:0];
    end else if (rounded < SAT_MIN) begin
      return SAT_MIN[DATA_W-1:0];
    end
    return rounded[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/fir_channel.sv
// One FIR channel: delay line, registered products, adder tree with round/saturate output register.
// The delay line moves only on shift_en; every other stage advances on ce.
module fir_channel
  import qpsk_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ce,
  input  logic                     shift_en,
  input  logic signed [DATA_W-1:0] din,
  output logic signed [DATA_W-1:0] dout
);

  logic signed [DATA_W-1:0] taps_q [NTAPS];
  logic signed [DATA_W-1:0] taps_d [NTAPS];
  logic signed [PROD_W-1:0] prod_q [NTAPS];
  logic signed [PROD_W-1:0] prod_d [NTAPS];
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] dout_q;
  logic signed [DATA_W-1:0] dout_d;

  always_comb begin
    taps_d = taps_q;
    if (shift_en) begin
      taps_d[0] = din;
      for (int k = 1; k < NTAPS; k++) begin
        taps_d[k] = taps_q[k-1];
      end
    end
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k < NTAPS; k++) begin
      prod_d[k] = ce ? (PROD_W'(taps_q[k]) * PROD_W'(COEF[k])) : prod_q[k];
      acc       = acc + ACC_W'(prod_q[k]);
    end
    dout_d = ce ? round_sat(acc) : dout_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NTAPS; k++) begin
        taps_q[k] <= '0;
        prod_q[k] <= '0;
      end
      dout_q <= '0;
    end else begin
      taps_q <= taps_d;
      prod_q <= prod_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/qpsk_pulse_shaper.sv
// QPSK transmit pulse shaper: two FIR channels (I in [15:0], Q in [31:16]) behind one
// AXI-Stream-style handshake; a single enable stalls the whole pipeline under backpressure.
module qpsk_pulse_shaper
  import qpsk_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_tdata,
  input  logic        in_tvalid,
  output logic        in_tready,
  output logic [31:0] out_tdata,
  output logic        out_tvalid,
  input  logic        out_tready
);

  logic ce;
  logic accepted;
  logic v1_q, v1_d;
  logic v2_q, v2_d;
  logic out_tvalid_q, out_tvalid_d;
  logic signed [DATA_W-1:0] out_i;
  logic signed [DATA_W-1:0] out_q;

  // The pipeline may advance whenever the output register is empty or being drained.
  always_comb begin
    ce           = !out_tvalid_q || out_tready;
    accepted     = in_tvalid && ce;
    v1_d         = v1_q;
    v2_d         = v2_q;
    out_tvalid_d = out_tvalid_q;
    if (ce) begin
      v1_d         = accepted;
      v2_d         = v1_q;
      out_tvalid_d = v2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      out_tvalid_q <= 1'b0;
    end else begin
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      out_tvalid_q <= out_tvalid_d;
    end
  end

  fir_channel u_fir_i (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .shift_en (accepted),
    .din      (in_tdata[15:0]),
    .dout     (out_i)
  );

  fir_channel u_fir_q (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .shift_en (accepted),
    .din      (in_tdata[31:16]),
    .dout     (out_q)
  );

  assign in_tready  = ce;
  assign out_tvalid = out_tvalid_q;
  assign out_tdata  = {out_q, out_i};

endmodule

// File: tb/tb_qpsk_pulse_shaper.sv
// Self-checking bench for qpsk_pulse_shaper: directed steps feeding a scoreboard of
// expected outputs computed by an independent integer FIR model.
module tb_qpsk_pulse_shaper;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_tdata = '0;
  logic        in_tvalid = 1'b0;
  logic        in_tready;
  logic [31:0] out_tdata;
  logic        out_tvalid;
  logic        out_tready = 1'b1;

  int checks = 0;
  int passes = 0;
  int acc_count = 0;
  int out_count = 0;

  logic [31:0] sb_q[$];
  int hist_i [17];
  int hist_q [17];
  int coef_tb [17] = '{-200, -300, 0, 600, 1200, 2000, 2800, 3500, 13568,
                       3500, 2800, 2000, 1200, 600, 0, -300, -200};

  logic        fired;
  logic [31:0] last_out;
  logic        obs_valid;
  logic        obs_ready;
  logic [31:0] obs_data;

  qpsk_pulse_shaper dut (
    .clk        (clk),
    .reset      (reset),
    .in_tdata   (in_tdata),
    .in_tvalid  (in_tvalid),
    .in_tready  (in_tready),
    .out_tdata  (out_tdata),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog timeout checks=%0d passes=%0d", checks, passes);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] modelFir(input int hist [17]);
    longint sum;
    longint r;
    sum = 0;
    for (int k = 0; k < 17; k++) begin
      sum += longint'(hist[k]) * longint'(coef_tb[k]);
    end
    r = (sum + 64'sd16384) >>> 15;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    return 16'(r);
  endfunction

  task automatic modelAccept(input logic [15:0] di, input logic [15:0] dq);
    for (int k = 16; k > 0; k--) begin
      hist_i[k] = hist_i[k-1];
      hist_q[k] = hist_q[k-1];
    end
    hist_i[0] = int'($signed(di));
    hist_q[0] = int'($signed(dq));
    sb_q.push_back({modelFir(hist_q), modelFir(hist_i)});
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // One clock of stimulus; handshakes are evaluated mid-cycle so they match what the next edge sees.
  task automatic applyStimulus(input logic vld, input logic [15:0] di, input logic [15:0] dq,
                               input logic rdy);
    logic [31:0] exp;
    in_tvalid  = vld;
    in_tdata   = {dq, di};
    out_tready = rdy;
    @(negedge clk);
    fired     = 1'b0;
    obs_valid = out_tvalid;
    obs_ready = in_tready;
    obs_data  = out_tdata;
    if (out_tvalid && out_tready) begin
      fired    = 1'b1;
      last_out = out_tdata;
      out_count++;
      exp = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hxxxxxxxx;
      checkOutput("scoreboard", out_tdata, exp);
    end
    if (in_tvalid && in_tready) begin
      modelAccept(di, dq);
      acc_count++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drainOutputs(input string tag);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
      n++;
    end
    checkOutput({tag, "_drain_left"}, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic doReset();
    reset      = 1'b1;
    in_tvalid  = 1'b0;
    out_tready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb_q.delete();
    for (int k = 0; k < 17; k++) begin
      hist_i[k] = 0;
      hist_q[k] = 0;
    end
  endtask

  task automatic checkResetState(input string tag);
    @(negedge clk);
    checkOutput({tag, "_out_tvalid"}, {31'h0, out_tvalid}, 32'd0);
    checkOutput({tag, "_out_tdata"}, out_tdata, 32'h0);
    checkOutput({tag, "_in_tready"}, {31'h0, in_tready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic runImpulse(input string tag);
    int n;
    n = 0;
    applyStimulus(1'b1, 16'h7FFF, 16'h0, 1'b1);
    for (int s = 1; s <= 19; s++) begin
      applyStimulus(1'b1, 16'h0, 16'h0, 1'b1);
      if (fired) begin
        if (n == 0) checkOutput({tag, "_latency"}, 32'(s), 32'd3);
        if (n < 17) checkOutput($sformatf("%s_tap%0d", tag, n), last_out, {16'h0, 16'(coef_tb[n])});
        n++;
      end
    end
    checkOutput({tag, "_count"}, 32'(n), 32'd17);
    drainOutputs(tag);
  endtask

  initial begin
    logic [31:0] stall_ref;
    int base_acc;
    int base_out;
    int cyc;

    $display("[TB] start");
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkResetState("init");

    runImpulse("impulse");

    for (int s = 0; s < 30; s++) applyStimulus(1'b1, 16'h6665, 16'h999B, 1'b1);
    drainOutputs("dc");
    checkOutput("dc_final", last_out, 32'h999B6665);

    for (int s = 0; s < 17; s++) begin
      applyStimulus(1'b1, (coef_tb[16-s] < 0) ? 16'h8001 : 16'h7FFF, 16'h0, 1'b1);
    end
    drainOutputs("sat_pos");
    checkOutput("sat_pos_peak", last_out, 32'h00007FFF);

    for (int s = 0; s < 17; s++) begin
      applyStimulus(1'b1, (coef_tb[16-s] < 0) ? 16'h7FFF : 16'h8001, 16'h0, 1'b1);
    end
    drainOutputs("sat_neg");
    checkOutput("sat_neg_peak", last_out, 32'h00008000);

    stall_ref = '0;
    for (int s = 0; s < 8; s++) applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'b1);
    for (int s = 0; s < 5; s++) begin
      applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'b0);
      checkOutput("bp_out_tvalid", {31'h0, obs_valid}, 32'd1);
      checkOutput("bp_in_tready", {31'h0, obs_ready}, 32'd0);
      if (s == 0) stall_ref = obs_data;
      else checkOutput("bp_hold", obs_data, stall_ref);
    end
    for (int s = 0; s < 8; s++) applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'b1);
    drainOutputs("bp");

    base_acc = acc_count;
    base_out = out_count;
    cyc = 0;
    while ((acc_count - base_acc) < 10000 && cyc < 60000) begin
      applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                    1'($urandom_range(0, 1)));
      cyc++;
    end
    checkOutput("rand_accepted", 32'(acc_count - base_acc), 32'd10000);
    drainOutputs("rand");
    checkOutput("rand_out_count", 32'(out_count - base_out), 32'(acc_count - base_acc));

    applyStimulus(1'b1, 16'h1234, 16'hBEEF, 1'b1);
    applyStimulus(1'b1, 16'h7FFF, 16'h8001, 1'b1);
    doReset();
    checkResetState("mid_rst");
    runImpulse("post_rst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
